// File: rtl/pipe_register.sv
// pipe_register: DEPTH-stage valid/ready register chain with bubble collapse, flush and occupancy count
module pipe_register #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] count
);
   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] v_nxt;
   logic [DEPTH:0]   rdy;
   logic [DEPTH:0]   vc;
   logic [WIDTH-1:0] d  [DEPTH];
   logic [WIDTH-1:0] dc [DEPTH+1];
   logic [CNT_W-1:0] cnt_nxt;
   assign vc = {v, in_valid};
   assign rdy[DEPTH] = out_ready;
   for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
      assign rdy[i] = out_ready | ~&v[DEPTH-1:i];
   end
   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   // next valid bits, predecessor data view and resulting occupancy
   always_comb begin
      v_nxt   = v;
      cnt_nxt = '0;
      dc[0]   = in_data;
      for (int k = 0; k < DEPTH; k++) begin
         dc[k+1]  = d[k];
         v_nxt[k] = rdy[k] ? vc[k] : v[k];
         cnt_nxt  = cnt_nxt + CNT_W'(v_nxt[k]);
      end
   end
   // advance stages; data loads only from a valid predecessor, flush drops valids only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v     <= '0;
         count <= '0;
         for (int k = 0; k < DEPTH; k++) d[k] <= '0;
      end else begin
         v     <= flush ? '0 : v_nxt;
         count <= flush ? '0 : cnt_nxt;
         for (int k = 0; k < DEPTH; k++)
            if (!flush && rdy[k] && vc[k]) d[k] <= dc[k];
      end
   end
endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: directed and randomized checks of pipe_register against a queue model
module tb_pipe_register;
   localparam int W = 8;
   localparam int D = 3;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         flush = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   count;
   int           checks = 0;
   int           failures = 0;
   int           e = 0;
   logic [W-1:0] q_d[$];
   int           q_t[$];
   logic [W-1:0] got[$];
   logic [W-1:0] exp_out[$];

   pipe_register #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .count(count)
   );

   always #5 clk = ~clk;

   // the oldest item reaches the last stage DEPTH-1 edges after acceptance, nothing ever blocks it earlier
   function automatic bit m_valid();
      return q_d.size() > 0 && (e - q_t[0]) >= D - 1;
   endfunction

   function automatic bit m_ready();
      return !flush && (q_d.size() < D || out_ready);
   endfunction

   task automatic tick(output bit acc);
      bit emt;
      #1;
      acc = in_valid && m_ready();
      emt = m_valid() && out_ready;
      if (out_valid && out_ready) got.push_back(out_data);
      if (emt) exp_out.push_back(q_d[0]);
      @(posedge clk);
      e++;
      if (emt) begin q_d.pop_front(); q_t.pop_front(); end
      if (flush) begin q_d.delete(); q_t.delete(); end
      else if (acc) begin q_d.push_back(in_data); q_t.push_back(e); end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bit a;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%0h exp=0", out_data); end
      checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h11; tick(a);
      in_data = 8'h22; tick(a);
      in_valid = 1'b0;
      checks++; if (count !== 2'd2) begin failures++; $display("FAIL pre_reset_count got=%0d exp=2", count); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%0b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL async_data got=%0h exp=0", out_data); end
      checks++; if (count !== 2'd0) begin failures++; $display("FAIL async_count got=%0d exp=0", count); end
      q_d.delete(); q_t.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_stream();
      bit a;
      int acc_n, em, cnt;
      out_ready = 1'b1;
      for (int i = 0; i < 19; i++) begin
         in_valid = (i < 16);
         in_data = 8'(i + 1);
         tick(a);
         acc_n = (i + 1 < 16) ? i + 1 : 16;
         em = (i >= 2) ? i - 2 : 0;
         cnt = acc_n - em;
         checks++; if (int'(count) !== cnt) begin failures++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", i, count, cnt); end
         checks++; if (out_valid !== (i >= 2 && cnt > 0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%0b", i, out_valid); end
         if (i >= 2 && cnt > 0) begin
            checks++; if (out_data !== 8'(em + 1)) begin failures++; $display("FAIL stream_data cyc=%0d got=%0h exp=%0h", i, out_data, em + 1); end
         end
      end
   endtask

   task automatic test_stall_fill();
      bit a;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin in_data = 8'hA0 + 8'(j); tick(a); end
      in_data = 8'hA3;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0b exp=0", in_ready); end
      checks++; if (count !== 2'd3) begin failures++; $display("FAIL stall_count got=%0d exp=3", count); end
      tick(a);
      checks++; if (out_data !== 8'hA0) begin failures++; $display("FAIL stall_hold got=%0h exp=a0", out_data); end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(j)) begin failures++; $display("FAIL drain_%0d got=%0b/%0h exp=1/%0h", j, out_valid, out_data, 8'hA0 + 8'(j)); end
         in_valid = (j == 0);
         tick(a);
      end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", out_valid); end
   endtask

   task automatic test_bubble();
      bit a;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h55; tick(a);
      in_valid = 1'b0; tick(a); tick(a);
      in_valid = 1'b1; in_data = 8'h66; tick(a);
      in_valid = 1'b0; tick(a);
      #1;
      checks++; if (count !== 2'd2) begin failures++; $display("FAIL bubble_count got=%0d exp=2", count); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bubble_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_data !== 8'h55) begin failures++; $display("FAIL bubble_head got=%0h exp=55", out_data); end
      out_ready = 1'b1;
      tick(a);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin failures++; $display("FAIL bubble_next got=%0b/%0h exp=1/66", out_valid, out_data); end
      tick(a);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bubble_empty got=%0b exp=0", out_valid); end
   endtask

   task automatic test_flush();
      bit a;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int j = 1; j <= 3; j++) begin in_data = 8'(j); tick(a); end
      checks++; if (count !== 2'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
      flush = 1'b1; in_data = 8'h04;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
      tick(a);
      flush = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (count !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
      out_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick(a);
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak cyc=%0d got=%0b/%0h exp=0", j, out_valid, out_data); end
      end
   endtask

   task automatic test_full_inout();
      bit a;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin in_data = 8'h10 + 8'(j); tick(a); end
      out_ready = 1'b1; in_data = 8'h7E;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready got=%0b exp=1", in_ready); end
      checks++; if (out_data !== 8'h10) begin failures++; $display("FAIL full_head got=%0h exp=10", out_data); end
      tick(a);
      in_valid = 1'b0;
      checks++; if (count !== 2'd3) begin failures++; $display("FAIL full_count got=%0d exp=3", count); end
      for (int j = 1; j < 4; j++) begin
         #1;
         checks++; if (out_valid !== 1'b1 || out_data !== ((j == 3) ? 8'h7E : 8'h10 + 8'(j))) begin failures++; $display("FAIL full_out_%0d got=%0b/%0h", j, out_valid, out_data); end
         tick(a);
      end
      checks++; if (count !== 2'd0) begin failures++; $display("FAIL full_drain_count got=%0d exp=0", count); end
   endtask

   task automatic test_random();
      bit a;
      got.delete(); exp_out.delete();
      in_valid = 1'b0; flush = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!in_valid || a) begin
            in_valid = ($urandom_range(9) < 7);
            in_data = 8'($urandom);
         end
         out_ready = ($urandom_range(9) < 6);
         flush = ($urandom_range(29) == 0);
         #1;
         checks++; if (out_valid !== m_valid()) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", i, out_valid, m_valid()); end
         checks++; if (int'(count) !== q_d.size()) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, q_d.size()); end
         checks++; if (in_ready !== m_ready()) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, m_ready()); end
         if (m_valid()) begin
            checks++; if (out_data !== q_d[0]) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0h exp=%0h", i, out_data, q_d[0]); end
         end
         tick(a);
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick(a);
      checks++; if (got.size() != exp_out.size()) begin failures++; $display("FAIL rnd_stream_len got=%0d exp=%0d", got.size(), exp_out.size()); end
      for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
         checks++; if (got[i] !== exp_out[i]) begin failures++; $display("FAIL rnd_order idx=%0d got=%0h exp=%0h", i, got[i], exp_out[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall_fill();
      test_bubble();
      test_flush();
      test_full_inout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
